mem_bus_decoder: RTL
====================

MEM_BUS_DECODER -- requirements
Module: mem_bus_decoder

Interface
REQ-001 Parameter RAM_BASE, default 32'h1000_0000, base of 128 KiB RAM window.
REQ-002 Parameter ROM_BASE, default 32'h0000_0000, base of 256 KiB ROM data window.
REQ-003 Parameter PER_BASE, default 32'h2000_0000, base of 64 KiB peripheral window.
REQ-004 Parameter PER_TIMEOUT, default 16, maximum peripheral wait in cycles (range 1..255).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 mem_addr / mem_wdata  in  32 / 32  core byte address and write data.
REQ-008 mem_byteen  in  4  core byte enables; mem_we  in  1  write strobe; mem_req  in  1  request pulse.
REQ-009 mem_rdata  out  32  registered read data; mem_ack  out  1  completion pulse; mem_err  out  1  error, valid with mem_ack.
REQ-010 ram_addr  out  15  word address; ram_we, ram_req  out  1 each; ram_byteen  out  4; ram_wdata  out  32; ram_rdata  in  32.
REQ-011 rom_addr  out  16  word address; rom_rden  out  1; rom_rdata  in  32.
REQ-012 per_addr  out  16; per_req, per_we  out  1 each; per_byteen  out  4; per_wdata  out  32; per_rdata  in  32; per_ack  in  1.

Function
REQ-013 Decode SHALL be purely address-range based: RAM if addr[31:17]==RAM_BASE[31:17], ROM if addr[31:18]==ROM_BASE[31:18], PER if addr[31:16]==PER_BASE[31:16], else UNMAPPED.
REQ-014 FSM states SHALL be IDLE, RAM_WAIT, ROM_WAIT, PER_WAIT, RESP.
REQ-015 In IDLE, mem_req high SHALL latch addr/wdata/byteen/we and select the target in the same cycle; mem_req is ignored in all other states.
REQ-016 RAM: ram_req (with ram_we=mem_we) SHALL pulse for exactly the accept cycle; IDLE->RAM_WAIT; next cycle capture ram_rdata (reads only), go RESP.
REQ-017 ROM read: rom_rden SHALL pulse on the accept cycle; IDLE->ROM_WAIT; next cycle capture rom_rdata, go RESP.
REQ-018 ROM write: no ROM strobe; IDLE->RESP with error flag set.
REQ-019 PER: per_req/per_we/per_addr/per_wdata/per_byteen SHALL be held from accept until per_ack or timeout; counter counts PER_WAIT cycles.
REQ-020 per_ack in PER_WAIT SHALL capture per_rdata (reads) and go RESP, no error; per_ack in PER_WAIT_count==PER_TIMEOUT cycle wins over timeout.
REQ-021 Counter reaching PER_TIMEOUT without per_ack SHALL drop per_req, go RESP with error; a per_ack arriving outside PER_WAIT is ignored.
REQ-022 UNMAPPED or mem_byteen==4'b0000: no target strobe, IDLE->RESP with error.
REQ-023 RESP SHALL assert mem_ack for exactly one cycle with mem_err, then return to IDLE.
REQ-024 Latency req->ack: RAM/ROM 2 cycles; errors 1 cycle; PER ack-cycle+1 or PER_TIMEOUT+1.
REQ-025 mem_rdata SHALL update only on successful reads and hold its value otherwise, including across writes and errors.
REQ-026 Target address outputs SHALL be mem_addr word bits ([16:2], [17:2], [15:2]); all target strobes low outside their defined cycles.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, mem_rdata 0, and all strobes, mem_ack, mem_err low.
REQ-028 Reset mid-transaction SHALL abort without ack; first request after rst_n rises is accepted normally.

Verification
REQ-029 RAM write 0x1000_0010 data 0xDEADBEEF byteen 4'hF, then read -> ram_addr 0x0004, ack at +2, rdata 0xDEADBEEF, err 0.
REQ-030 ROM read 0x0000_0100, rom_rdata 0x00000013 -> rom_rden one pulse, rom_addr 0x0040, ack at +2, rdata 0x00000013; ROM write -> ack at +1, err 1, no rom_rden.
REQ-031 PER read 0x2000_0008, per_ack after 3 cycles with 0x55AA55AA -> per_req held 3 cycles, ack next cycle, rdata 0x55AA55AA, err 0.
REQ-032 PER read, no per_ack, PER_TIMEOUT=16 -> per_req dropped after 16 cycles, ack err 1, rdata unchanged.
REQ-033 Access 0x3000_0000 and byteen 0 -> ack at +1 err 1; mem_req pulses while busy ignored (exactly one ack).
REQ-034 rst_n low during PER_WAIT -> per_req low asynchronously, no ack; following RAM read completes in 2 cycles.

Source files
------------

// File: rtl/mem_bus_decoder.sv
// Single-outstanding memory bus decoder: steers core requests to RAM, ROM or a
// peripheral port by address range and returns a one-cycle ack with error flag.
//
// state    | meaning
// IDLE     | waiting for mem_req; target strobe driven in the accept cycle
// RAM_WAIT | RAM access issued last cycle; capture ram_rdata on reads
// ROM_WAIT | ROM read issued last cycle; capture rom_rdata
// PER_WAIT | peripheral request held until per_ack or timeout
// RESP     | mem_ack (with mem_err) asserted for one cycle
module mem_bus_decoder #(
  parameter logic [31:0] RAM_BASE    = 32'h1000_0000,
  parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
  parameter logic [31:0] PER_BASE    = 32'h2000_0000,
  parameter int unsigned PER_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byteen,
  input  logic        mem_we,
  input  logic        mem_req,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        mem_err,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic        ram_req,
  output logic [3:0]  ram_byteen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [15:0] rom_addr,
  output logic        rom_rden,
  input  logic [31:0] rom_rdata,
  output logic [15:0] per_addr,
  output logic        per_req,
  output logic        per_we,
  output logic [3:0]  per_byteen,
  output logic [31:0] per_wdata,
  input  logic [31:0] per_rdata,
  input  logic        per_ack
);

  localparam logic [7:0] TIMEOUT = 8'(PER_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_WAIT,
    S_ROM_WAIT,
    S_PER_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  byteen_q, byteen_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic hit_ram, hit_rom, hit_per, be_ok;
  logic accept, go_ram, go_rom, go_per;
  logic per_hold;
  logic unused_addr;

  // Byte-lane bits never reach a target; all targets are word addressed.
  assign unused_addr = ^mem_addr[1:0];

  assign hit_ram = (mem_addr[31:17] == RAM_BASE[31:17]);
  assign hit_rom = (mem_addr[31:18] == ROM_BASE[31:18]);
  assign hit_per = (mem_addr[31:16] == PER_BASE[31:16]);
  assign be_ok   = (mem_byteen != 4'b0000);

  // rst_n gating keeps the combinational accept strobes quiet while in reset.
  assign accept = rst_n && (state_q == S_IDLE) && mem_req;
  assign go_ram = accept && be_ok && hit_ram;
  assign go_rom = accept && be_ok && !hit_ram && hit_rom && !mem_we;
  assign go_per = accept && be_ok && !hit_ram && !hit_rom && hit_per;

  assign per_hold = (state_q == S_PER_WAIT);

  assign ram_req    = go_ram;
  assign ram_we     = go_ram & mem_we;
  assign ram_byteen = go_ram ? mem_byteen : 4'b0000;
  assign ram_addr   = mem_addr[16:2];
  assign ram_wdata  = mem_wdata;

  assign rom_rden = go_rom;
  assign rom_addr = mem_addr[17:2];

  // The accept cycle drives the live bus; PER_WAIT replays the latched copy.
  assign per_req    = go_per | per_hold;
  assign per_we     = go_per ? mem_we : (per_hold & we_q);
  assign per_addr   = per_hold ? {2'b00, addr_q} : {2'b00, mem_addr[15:2]};
  assign per_byteen = go_per ? mem_byteen : (per_hold ? byteen_q : 4'b0000);
  assign per_wdata  = per_hold ? wdata_q : mem_wdata;

  assign mem_rdata = rdata_q;
  assign mem_ack   = ack_q;
  assign mem_err   = err_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    byteen_d = byteen_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = mem_addr[15:2];
          wdata_d  = mem_wdata;
          byteen_d = mem_byteen;
          we_d     = mem_we;
          if (go_ram) begin
            state_d = S_RAM_WAIT;
          end else if (go_rom) begin
            state_d = S_ROM_WAIT;
          end else if (go_per) begin
            state_d = S_PER_WAIT;
            cnt_d   = 8'd1;
          end else begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      S_RAM_WAIT: begin
        if (!we_q) rdata_d = ram_rdata;
        state_d = S_RESP;
        ack_d   = 1'b1;
      end

      S_ROM_WAIT: begin
        rdata_d = rom_rdata;
        state_d = S_RESP;
        ack_d   = 1'b1;
      end

      S_PER_WAIT: begin
        // cnt_q numbers the current PER_WAIT cycle, so an ack on the last
        // allowed cycle is seen before the timeout compare.
        if (per_ack) begin
          if (!we_q) rdata_d = per_rdata;
          state_d = S_RESP;
          ack_d   = 1'b1;
          cnt_d   = 8'd0;
        end else if (cnt_q >= TIMEOUT) begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      byteen_q <= byteen_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

endmodule
